// File: rtl/if_fetch_queue.sv
// rtl/if_fetch_queue.sv - instruction fetch stage with in-order prefetch queue
//
// Issues sequential instruction fetches over a req/gnt/rvalid handshake and
// buffers returned words together with their PC and PC+4 in a DEPTH-entry FIFO
// feeding ID. The PC of every granted request is recorded in an in-order tag
// FIFO so each response is paired with the address that produced it. Redirects
// flush the queue and turn every in-flight response into a drop credit, so
// stale words never reach ID and no fetch is replayed.
//
// Ports
//   clk, reset_n              clock (rising edge), asynchronous active-low reset
//   redirect, redirect_pc     flush and restart fetch at redirect_pc
//   imem_req, imem_addr       fetch request and address, held until imem_gnt
//   imem_gnt                  request accepted when imem_req & imem_gnt
//   imem_rvalid, imem_rdata   in-order fetch response
//   id_valid, id_ready        queue head handshake towards ID
//   id_ir, id_pc, id_pc_plus_4 queue head contents
//   perf_fetched, perf_dropped delivered / discarded counters (IF_PERF_EN only)
//
// Configuration
//   IF_PERF_EN  when defined, adds the perf_fetched / perf_dropped counters.

module if_fetch_queue #(
    parameter int                ADDR_W   = 32,
    parameter int                DATA_W   = 32,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(32'h00400000)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_gnt,
    input  logic              imem_rvalid,
    input  logic [DATA_W-1:0] imem_rdata,
    output logic              id_valid,
    input  logic              id_ready,
    output logic [DATA_W-1:0] id_ir,
    output logic [ADDR_W-1:0] id_pc,
    output logic [ADDR_W-1:0] id_pc_plus_4
`ifdef IF_PERF_EN
    ,
    output logic [31:0]       perf_fetched,
    output logic [31:0]       perf_dropped
`endif
);

    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    // Drop credits can pile up across several redirects while memory is slow,
    // so this counter is wider than the queue occupancy counters.
    localparam int DROP_W = CNT_W + 8;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic              started_q,     started_d;
    logic [ADDR_W-1:0] fetch_pc_q,    fetch_pc_d;
    logic [CNT_W-1:0]  count_q,       count_d;
    logic [CNT_W-1:0]  outstanding_q, outstanding_d;
    logic [DROP_W-1:0] drop_q,        drop_d;
    logic [PTR_W-1:0]  rd_ptr_q,      rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q,      wr_ptr_d;
    logic [PTR_W-1:0]  tag_rd_ptr_q,  tag_rd_ptr_d;
    logic [PTR_W-1:0]  tag_wr_ptr_q,  tag_wr_ptr_d;

    logic [DATA_W-1:0] ir_mem_q  [DEPTH];
    logic [DATA_W-1:0] ir_mem_d  [DEPTH];
    logic [ADDR_W-1:0] pc_mem_q  [DEPTH];
    logic [ADDR_W-1:0] pc_mem_d  [DEPTH];
    logic [ADDR_W-1:0] pc4_mem_q [DEPTH];
    logic [ADDR_W-1:0] pc4_mem_d [DEPTH];
    logic [ADDR_W-1:0] tag_mem_q [DEPTH];
    logic [ADDR_W-1:0] tag_mem_d [DEPTH];

`ifdef IF_PERF_EN
    logic [31:0]       perf_fetched_q, perf_fetched_d;
    logic [31:0]       perf_dropped_q, perf_dropped_d;
`endif

    // ------------------------------------------------------------------
    // Handshake decode
    // ------------------------------------------------------------------
    logic              credit_ok;
    logic              gnt_fire;
    logic              rsp_inflight;
    logic              rsp_keep;
    logic              rsp_drop;
    logic              pop;
    logic [ADDR_W-1:0] rsp_pc;

    always_comb begin
        // Queued entries plus in-flight requests never exceed DEPTH, which is
        // what guarantees a kept response always finds a free slot.
        credit_ok    = ((CNT_W+1)'(count_q) + (CNT_W+1)'(outstanding_q))
                       < (CNT_W+1)'(DEPTH);
        // The request is masked in a redirect cycle, so no grant can be
        // accepted there; anything granted earlier moves into drop below.
        imem_req     = started_q && credit_ok && !redirect;
        imem_addr    = fetch_pc_q;
        gnt_fire     = imem_req && imem_gnt;

        rsp_inflight = (drop_q != '0) || (outstanding_q != '0);
        rsp_keep     = imem_rvalid && !redirect && (drop_q == '0)
                       && (outstanding_q != '0);
        rsp_drop     = imem_rvalid && rsp_inflight && !rsp_keep;
        rsp_pc       = tag_mem_q[tag_rd_ptr_q];

        id_valid     = (count_q != '0);
        pop          = id_valid && id_ready;
        id_ir        = ir_mem_q[rd_ptr_q];
        id_pc        = pc_mem_q[rd_ptr_q];
        id_pc_plus_4 = pc4_mem_q[rd_ptr_q];
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        started_d     = 1'b1;
        fetch_pc_d    = fetch_pc_q;
        count_d       = count_q;
        outstanding_d = outstanding_q;
        drop_d        = drop_q;
        rd_ptr_d      = rd_ptr_q;
        wr_ptr_d      = wr_ptr_q;
        tag_rd_ptr_d  = tag_rd_ptr_q;
        tag_wr_ptr_d  = tag_wr_ptr_q;
        ir_mem_d      = ir_mem_q;
        pc_mem_d      = pc_mem_q;
        pc4_mem_d     = pc4_mem_q;
        tag_mem_d     = tag_mem_q;

        if (redirect) begin
            // Everything still in flight becomes a drop credit; a response
            // arriving this very cycle is one of them and is already gone.
            fetch_pc_d    = redirect_pc;
            count_d       = '0;
            outstanding_d = '0;
            rd_ptr_d      = '0;
            wr_ptr_d      = '0;
            tag_rd_ptr_d  = '0;
            tag_wr_ptr_d  = '0;
            drop_d        = drop_q + DROP_W'(outstanding_q)
                            - DROP_W'(imem_rvalid && rsp_inflight);
        end else begin
            if (gnt_fire) begin
                fetch_pc_d              = fetch_pc_q + ADDR_W'(4);
                tag_mem_d[tag_wr_ptr_q] = fetch_pc_q;
                tag_wr_ptr_d            = tag_wr_ptr_q + PTR_W'(1);
            end

            if (rsp_drop) begin
                drop_d = drop_q - DROP_W'(1);
            end

            if (rsp_keep) begin
                ir_mem_d[wr_ptr_q]  = imem_rdata;
                pc_mem_d[wr_ptr_q]  = rsp_pc;
                pc4_mem_d[wr_ptr_q] = rsp_pc + ADDR_W'(4);
                wr_ptr_d            = wr_ptr_q + PTR_W'(1);
                tag_rd_ptr_d        = tag_rd_ptr_q + PTR_W'(1);
            end

            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end

            count_d       = count_q + CNT_W'(rsp_keep) - CNT_W'(pop);
            outstanding_d = outstanding_q + CNT_W'(gnt_fire) - CNT_W'(rsp_keep);
        end
    end

`ifdef IF_PERF_EN
    always_comb begin
        perf_fetched_d = perf_fetched_q + 32'(pop);
        perf_dropped_d = perf_dropped_q + 32'(rsp_drop);
    end

    assign perf_fetched = perf_fetched_q;
    assign perf_dropped = perf_dropped_q;
`endif

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            started_q     <= 1'b0;
            fetch_pc_q    <= RESET_PC;
            count_q       <= '0;
            outstanding_q <= '0;
            drop_q        <= '0;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            tag_rd_ptr_q  <= '0;
            tag_wr_ptr_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                ir_mem_q[i]  <= '0;
                pc_mem_q[i]  <= '0;
                pc4_mem_q[i] <= '0;
                tag_mem_q[i] <= '0;
            end
        end else begin
            started_q     <= started_d;
            fetch_pc_q    <= fetch_pc_d;
            count_q       <= count_d;
            outstanding_q <= outstanding_d;
            drop_q        <= drop_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            tag_rd_ptr_q  <= tag_rd_ptr_d;
            tag_wr_ptr_q  <= tag_wr_ptr_d;
            ir_mem_q      <= ir_mem_d;
            pc_mem_q      <= pc_mem_d;
            pc4_mem_q     <= pc4_mem_d;
            tag_mem_q     <= tag_mem_d;
        end
    end

`ifdef IF_PERF_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            perf_fetched_q <= '0;
            perf_dropped_q <= '0;
        end else begin
            perf_fetched_q <= perf_fetched_d;
            perf_dropped_q <= perf_dropped_d;
        end
    end
`endif

endmodule
